// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared types and default sizing for the perceptron loader and training core.
//   state_t  - loader sequencing states
//   sample_t - one training sample at the default sizing {features, label}
package perceptron_pkg;
    localparam int INP_DIM_DEF = 2;
    localparam int N_SAMPLES_DEF = 3;
    localparam int DATA_W_DEF = 4;
    typedef enum logic [1:0] {LOAD, READY, RUN, DONE} state_t;
    typedef struct packed {
        logic [INP_DIM_DEF*DATA_W_DEF-1:0] features;
        logic                              label;
    } sample_t;
endpackage

// File: rtl/sample_store.sv
// sample_store: training-set register array, written one byte at a time, read by sample index.
//   clk       - clock (storage is not reset)
//   we        - write strobe for one byte
//   widx      - sample being written
//   fidx      - feature slot within that sample
//   is_label  - byte is the label (stores wdata[0]) rather than a feature
//   wdata     - truncated byte
//   ridx      - sample to read; rx/ry are its features/label
module sample_store
    import perceptron_pkg::*;
#(
    parameter int INP_DIM = INP_DIM_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1,
    localparam int PW = $clog2(INP_DIM + 1)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IW-1:0]             widx,
    input  logic [PW-1:0]             fidx,
    input  logic                      is_label,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [IW-1:0]             ridx,
    output logic [INP_DIM*DATA_W-1:0] rx,
    output logic                      ry
);
    // Same layout as sample_t, sized by this instance's parameters.
    typedef struct packed {
        logic [INP_DIM*DATA_W-1:0] features;
        logic                      label;
    } entry_t;
    entry_t mem [N_SAMPLES];
    always_ff @(posedge clk) begin
        if (we && is_label) mem[widx].label <= wdata[0];
        else if (we) mem[widx].features[fidx*DATA_W +: DATA_W] <= wdata;
    end
    assign rx = mem[ridx].features;
    assign ry = mem[ridx].label;
endmodule

// File: rtl/perceptron_sample_loader.sv
// perceptron_sample_loader: byte-serial training-set loader and epoch replay sequencer.
//   clk, rst (async, active-high)
//   wr_valid/wr_data/wr_ready       - byte load port (features then label per sample)
//   load, start, stop               - reload, begin replay, early stop (converged)
//   smp_valid/smp_ready/smp_x/smp_y/smp_last - sample stream to the training core
//   epoch_done, busy, err           - epoch pulse, replay active, sticky malformed-byte flag
// Optional: PERCEPTRON_LOADER_ERRCHK_EN enables out-of-range byte detection on err.
module perceptron_sample_loader
    import perceptron_pkg::*;
#(
    parameter int INP_DIM = INP_DIM_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int EPOCHS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_data,
    output logic                      wr_ready,
    input  logic                      load,
    input  logic                      start,
    input  logic                      stop,
    output logic                      smp_valid,
    input  logic                      smp_ready,
    output logic [INP_DIM*DATA_W-1:0] smp_x,
    output logic                      smp_y,
    output logic                      smp_last,
    output logic                      epoch_done,
    output logic                      busy,
    output logic                      err
);
    localparam int TOTAL = N_SAMPLES * (INP_DIM + 1);
    localparam int BW = $clog2(TOTAL + 1);
    localparam int IW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
    localparam int EW = $clog2(EPOCHS + 1);
    localparam int PW = $clog2(INP_DIM + 1);
    state_t state, state_nxt;
    logic [BW-1:0] bcnt;
    logic [PW-1:0] pos;
    logic [IW-1:0] widx, idx, idx_nxt;
    logic [EW-1:0] epoch;
    logic [INP_DIM*DATA_W-1:0] rd_x;
    logic rd_y, we, is_label, hs, go, wrap, fin, present;
    assign we = wr_valid && wr_ready && !load;
    assign is_label = pos == PW'(INP_DIM);
    assign hs = smp_valid && smp_ready;
    assign go = start && (state == READY || state == DONE);
    assign wrap = idx == IW'(N_SAMPLES - 1);
    assign fin = hs && wrap && epoch == EW'(EPOCHS - 1);
    assign busy = state == RUN;
    // Present a sample whenever RUN continues into the next cycle; the first RUN
    // cycle after start has smp_valid low and fills the output registers.
    assign present = state == RUN && state_nxt == RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = load ? LOAD :
                    (state == LOAD && we && bcnt == BW'(TOTAL - 1)) ? READY :
                    go ? RUN :
                    (state == RUN && (stop || fin)) ? DONE : state;
        idx_nxt = go ? '0 : !hs ? idx : wrap ? '0 : idx + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready <= 1'b1;
            smp_valid <= 1'b0;
            smp_x <= '0;
            smp_y <= 1'b0;
            smp_last <= 1'b0;
            epoch_done <= 1'b0;
            bcnt <= '0;
            pos <= '0;
            widx <= '0;
            idx <= '0;
            epoch <= '0;
        end else begin
            wr_ready <= state_nxt == LOAD;
            smp_valid <= present;
            epoch_done <= hs && wrap && !load;
            idx <= idx_nxt;
            epoch <= go ? '0 : (hs && wrap) ? epoch + 1'b1 : epoch;
            if (load) begin
                bcnt <= '0;
                pos <= '0;
                widx <= '0;
            end else if (we) begin
                bcnt <= bcnt + 1'b1;
                pos <= is_label ? '0 : pos + 1'b1;
                widx <= widx + IW'(is_label);
            end
            // Output registers only move on a handshake or the initial fill, so
            // they hold steady under backpressure.
            if (present && (hs || !smp_valid)) begin
                smp_x <= rd_x;
                smp_y <= rd_y;
                smp_last <= idx_nxt == IW'(N_SAMPLES - 1);
            end
        end
    end
`ifdef PERCEPTRON_LOADER_ERRCHK_EN
    logic bad;
    assign bad = is_label ? (wr_data > 8'd1) : ((wr_data >> DATA_W) != 8'd0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (load) err <= 1'b0;
        else if (we && bad) err <= 1'b1;
    end
`else
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;
    assign err = 1'b0;
`endif
    sample_store #(
        .INP_DIM(INP_DIM),
        .N_SAMPLES(N_SAMPLES),
        .DATA_W(DATA_W)
    ) u_store (
        .clk(clk),
        .we(we),
        .widx(widx),
        .fidx(pos),
        .is_label(is_label),
        .wdata(wr_data[DATA_W-1:0]),
        .ridx(idx_nxt),
        .rx(rd_x),
        .ry(rd_y)
    );
endmodule

// File: tb/tb_perceptron_sample_loader.sv
// tb_perceptron_sample_loader: directed self-checking bench for perceptron_sample_loader (default parameters).
module tb_perceptron_sample_loader;
    logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, smp_ready = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic wr_ready, smp_valid, smp_y, smp_last, epoch_done, busy, err;
    logic [7:0] smp_x;
    int checks = 0, errors = 0, ed = 0, n = 0;
    logic [7:0] set_b [9] = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h04, 8'h05, 8'h01};
    logic [7:0] exp_x [3] = '{8'h32, 8'h54, 8'h54};
    logic exp_y [3] = '{1'b0, 1'b1, 1'b1};
`ifdef PERCEPTRON_LOADER_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif
    perceptron_sample_loader dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .load(load), .start(start), .stop(stop), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_last(smp_last), .epoch_done(epoch_done),
        .busy(busy), .err(err)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic load_set(input logic [7:0] b0);
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data = (i == 0) ? b0 : set_b[i];
            tick();
        end
        wr_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        repeat (2) tick();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_valid", smp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_epoch_done", epoch_done, 0);
        check("rst_last", smp_last, 0);
        check("rst_x", smp_x, 0);
        rst = 1'b0;
        tick();
        load_set(8'h02);
        check("ld_wr_ready", wr_ready, 0);
        check("ld_busy", busy, 0);
        check("ld_err", err, 0);
        check("ld_valid", smp_valid, 0);
        start = 1'b1;
        smp_ready = 1'b1;
        tick();
        start = 1'b0;
        check("start_lat_valid", smp_valid, 0);
        check("start_busy", busy, 1);
        tick();
        for (int k = 0; k < 24; k++) begin
            check("run_valid", smp_valid, 1);
            check("run_x", smp_x, exp_x[k % 3]);
            check("run_y", smp_y, exp_y[k % 3]);
            check("run_last", smp_last, k % 3 == 2);
            check("run_epoch_done", epoch_done, k > 0 && k % 3 == 0);
            if (epoch_done) ed++;
            tick();
        end
        check("end_valid", smp_valid, 0);
        check("end_busy", busy, 0);
        check("end_epoch_done", epoch_done, 1);
        if (epoch_done) ed++;
        check("epoch_pulses", ed, 8);
        tick();
        check("end_epoch_done_clr", epoch_done, 0);
        smp_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("bp_s0_valid", smp_valid, 1);
        check("bp_s0_x", smp_x, 8'h32);
        smp_ready = 1'b1;
        tick();
        smp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", smp_valid, 1);
            check("bp_hold_x", smp_x, 8'h54);
            check("bp_hold_y", smp_y, 1);
            check("bp_hold_last", smp_last, 0);
        end
        smp_ready = 1'b1;
        tick();
        check("bp_s2_last", smp_last, 1);
        tick();
        check("e1_s0_x", smp_x, 8'h32);
        check("e1_epoch_done", epoch_done, 1);
        repeat (3) tick();
        check("e2_s0_x", smp_x, 8'h32);
        check("e2_epoch_done", epoch_done, 1);
        tick();
        check("e2_s1_x", smp_x, 8'h54);
        check("e2_s1_last", smp_last, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", smp_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_epoch_done", epoch_done, 0);
        tick();
        check("stop_valid_hold", smp_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_valid", smp_valid, 1);
        check("restart_x", smp_x, 8'h32);
        check("restart_last", smp_last, 0);
        n = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            if (smp_valid && smp_ready) n++;
            tick();
        end
        check("restart_handshakes", n, 24);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_pre_valid", smp_valid, 1);
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        check("abort_valid", smp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_wr_ready", wr_ready, 1);
        load_set(8'h1A);
        check("reload_wr_ready", wr_ready, 0);
        check("reload_err", err, ERR_EXP);
        smp_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("reload_x", smp_x, 8'h3A);
        check("reload_y", smp_y, 0);
        check("run_err", err, ERR_EXP);
        check("reload_busy", busy, 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("load_err_clr", err, 0);
        check("load_wr_ready", wr_ready, 1);
        check("load_valid", smp_valid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/perceptron_sample_loader.md
# perceptron_sample_loader

Byte-serial training-set loader and replay sequencer that sits directly upstream of the perceptron training core. It accepts feature/label bytes from the tile's dedicated inputs and stores a full training set of `N_SAMPLES` samples. It then replays that set to the core for a programmable number of epochs over a valid/ready handshake, and supports early stop when the core reports convergence.

## Interface
Parameters:
- `INP_DIM`, default 2: features per sample.
- `N_SAMPLES`, default 3: samples per training set.
- `DATA_W`, default 4: feature width in bits (unsigned); the low bits of each feature byte.
- `EPOCHS`, default 8: full passes over the set per `start`; must be ≥1.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_valid`, in, 1: load byte valid.
- `wr_data`, in, 8: load byte.
- `wr_ready`, out, 1: loader accepts bytes (high only in LOAD).
- `load`, in, 1: pulse; discard the stored set and re-enter LOAD.
- `start`, in, 1: pulse; begin replay (accepted in READY or DONE).
- `stop`, in, 1: early stop from the core (converged).
- `smp_valid`, out, 1: sample presented.
- `smp_ready`, in, 1: core consumes the sample.
- `smp_x`, out, `INP_DIM*DATA_W`: features, feature 0 in the LSBs.
- `smp_y`, out, 1: label.
- `smp_last`, out, 1: presented sample is the last in the set.
- `epoch_done`, out, 1: one-cycle pulse at the end of each epoch.
- `busy`, out, 1: high in RUN.
- `err`, out, 1: sticky malformed-input flag.

## Operation
- States: LOAD, READY, RUN, DONE. Reset enters LOAD.
- **LOAD:** each accepted byte (`wr_valid && wr_ready`) is written in order.
  - Per sample, `INP_DIM` feature bytes come first, then one label byte.
  - Feature storage is `wr_data[DATA_W-1:0]`; label storage is `wr_data[0]`.
  - After `N_SAMPLES*(INP_DIM+1)` accepted bytes, go to READY. `wr_ready` is low from the next cycle.
- **READY:** `start` goes to RUN. The sample index and epoch counter are cleared.
- **RUN:** present sample[idx].
  - On handshake (`smp_valid && smp_ready`), idx increments.
  - When idx = `N_SAMPLES-1`, idx wraps to 0, `epoch_done` pulses and the epoch counter increments.
  - Handshake on `smp_last` of epoch `EPOCHS-1` goes to DONE.
- **stop in RUN:** go to DONE next cycle. If it coincides with a handshake, that handshake completes, including any `epoch_done` pulse.
- **DONE:** `start` replays the stored set from sample 0, epoch 0 (same as from READY).
- **load:** accepted in any state, including mid-RUN. It aborts replay: `smp_valid` drops, and the state goes to LOAD with byte counter = 0 and `err` cleared.
  - `load` wins over a simultaneous `start` or `stop`.
  - `start` while in LOAD or RUN is ignored.
- Counter widths:
  - byte counter: $clog2(N_SAMPLES*(INP_DIM+1)+1) bits.
  - idx: $clog2(N_SAMPLES) bits, minimum 1.
  - epoch counter: $clog2(EPOCHS+1) bits.
  - No overflow is possible by construction.

## Timing
- Reset values:
  - `wr_ready`=1.
  - `smp_valid`, `smp_x`, `smp_y`, `smp_last`, `epoch_done`, `busy`, `err` = 0.
  - Sample storage is not reset.
- Load throughput: 1 byte/cycle. `wr_ready` is registered.
- Start latency: `start` sampled at edge N gives `smp_valid`=1 after edge N+1, presenting sample 0.
- Replay throughput: 1 sample/cycle while `smp_ready` is held high.
- Stability: `smp_x`/`smp_y`/`smp_last` are registered and stable while `smp_valid && !smp_ready`. `smp_valid` never drops without a handshake, except on `stop`, `load` or reset.
- `epoch_done` is asserted in the cycle after the `smp_last` handshake, for exactly one cycle.
- `busy` equals (state == RUN).

## Configuration
- Macro: `PERCEPTRON_LOADER_ERRCHK_EN`.
- Defined: `err` is set (sticky) when a feature byte has any of `wr_data[7:DATA_W]` set, or a label byte is greater than 1. The byte is still stored, truncated as above. `err` clears on `load` or `rst` only.
- Undefined: `err` is tied to 0 and out-of-range bits are silently truncated.

## Structure
- Shared package `perceptron_pkg`: state enum (LOAD/READY/RUN/DONE), default `INP_DIM`/`N_SAMPLES`/`DATA_W` constants, and a sample struct {features, label}. The training core uses the same package.
- One sub-module: `sample_store`, a write-sequential / read-by-index register array of `N_SAMPLES` sample structs. The FSM, counters and handshake stay in the top module.

## Test plan
- Reset, then load 9 bytes (default parameters): 02,03,00, 04,05,01, 04,05,01. Then `wr_ready`=0, state READY, `err`=0.
- `start` with `smp_ready`=1 held: sample stream (x,y) = (0x32,0),(0x54,1),(0x54,1) repeats 8×. Expect `smp_last` on every third sample, 8 `epoch_done` pulses, `busy` low after 24 handshakes, first `smp_valid` 1 cycle after `start`.
- Backpressure: hold `smp_ready`=0 for 5 cycles mid-epoch. Sample values and `smp_valid` must hold stable, and idx must not advance.
- `stop` coincident with handshake of sample 1 in epoch 2: next state DONE, `smp_valid`=0, no extra samples. A subsequent `start` restarts at sample 0, epoch 0.
- `load` asserted together with `start` while in RUN: `smp_valid` drops next cycle, `wr_ready`=1, and a fresh 9-byte load is accepted.
- With `PERCEPTRON_LOADER_ERRCHK_EN`: feature byte 0x1A sets `err`=1 and stores 0xA. `err` stays set through RUN and clears on `load`. Without the macro, `err` stays 0.
